masked_rng_source: RTL and testbench

- Fresh-randomness source for the first-order masked gadgets (masked AND, refresh stages).
- Produces OUT_W fresh random bits per cycle from a seeded 32-bit Galois LFSR. The low two bits map directly onto a gadget's r0/r1 inputs.
- Handles seed loading over a byte-wide valid/ready channel and a warm-up period.
- Flags an error and withholds randomness if the generator state is zero.

---
 rtl/masked_rng_source.sv | 134 +++++++++++++
 tb/tb_masked_rng_source.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_rng_source.sv
// Fresh-randomness source for first-order masked gadgets: seeded 32-bit Galois LFSR, OUT_W bits per cycle.
// Latency: rnd comes straight from the state register; the first value appears WARMUP cycles after the last seed beat.
// Backpressure: seed beats are taken only while seed_ready is high; rnd holds until rnd_ready, so nothing is repeated or skipped.
module masked_rng_source #(
    parameter int                LFSR_W   = 32,
    parameter int                SEED_W   = 8,
    parameter int                OUT_W    = 2,
    parameter int                WARMUP   = 64,
    parameter logic [LFSR_W-1:0] TAP_MASK = 32'h80200003
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_start,
    input  logic [SEED_W-1:0] seed_data,
    input  logic              seed_valid,
    output logic              seed_ready,
    output logic [OUT_W-1:0]  rnd,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              err,
    output logic              busy
);

    localparam int SEED_BEATS = LFSR_W / SEED_W;
    localparam int BC_W       = (SEED_BEATS > 1) ? $clog2(SEED_BEATS) : 1;
    localparam int WC_W       = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(SEED_BEATS - 1);
    localparam logic [WC_W-1:0] WARM_INIT = WC_W'(WARMUP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARM,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [LFSR_W-1:0] lfsr, lfsr_nxt;
    logic [BC_W-1:0]   beat_cnt, beat_nxt;
    logic [WC_W-1:0]   warm_cnt, warm_nxt;
    logic [LFSR_W-1:0] seed_shift;
    logic              lfsr_nz;

    // OUT_W chained Galois right-shift steps, all within one cycle.
    function automatic logic [LFSR_W-1:0] advance(input logic [LFSR_W-1:0] v);
        logic [LFSR_W-1:0] x;
        x = v;
        for (int i = 0; i < OUT_W; i++) begin
            x = (x >> 1) ^ (x[0] ? TAP_MASK : '0);
        end
        return x;
    endfunction

    // Seed beats enter at the LSB end, so the first beat ends up in the MSBs.
    assign seed_shift = {lfsr[LFSR_W-SEED_W-1:0], seed_data};
    assign lfsr_nz    = |lfsr;

    assign seed_ready = (state == S_LOAD);
    assign busy       = (state == S_LOAD) || (state == S_WARM);
    assign err        = (state == S_ERROR);
    // Qualify on a non-zero state so a stuck-at-zero generator never presents output.
    assign rnd_valid  = (state == S_RUN) && lfsr_nz;
    assign rnd        = lfsr[OUT_W-1:0];

    // State and datapath registers; reset discards any partial seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            lfsr     <= '0;
            beat_cnt <= '0;
            warm_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            beat_cnt <= beat_nxt;
            warm_cnt <= warm_nxt;
        end
    end

    // Next-state and datapath update; seed_start overrides everything else and holds the LFSR.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        beat_nxt  = beat_cnt;
        warm_nxt  = warm_cnt;
        if (seed_start) begin
            state_nxt = S_LOAD;
            beat_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                end
                S_LOAD: begin
                    if (seed_valid) begin
                        lfsr_nxt = seed_shift;
                        if (beat_cnt == LAST_BEAT) begin
                            if (seed_shift == '0) begin
                                state_nxt = S_ERROR;
                            end else if (WARMUP == 0) begin
                                state_nxt = S_RUN;
                            end else begin
                                state_nxt = S_WARM;
                                warm_nxt  = WARM_INIT;
                            end
                        end else begin
                            beat_nxt = beat_cnt + BC_W'(1);
                        end
                    end
                end
                S_WARM: begin
                    lfsr_nxt = advance(lfsr);
                    warm_nxt = warm_cnt - WC_W'(1);
                    if (warm_cnt == WC_W'(1)) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!lfsr_nz) begin
                        state_nxt = S_ERROR;
                    end else if (rnd_ready) begin
                        lfsr_nxt = advance(lfsr);
                    end
                end
                S_ERROR: begin
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_rng_source.sv
// Bench for masked_rng_source: directed vector table on a WARMUP=0 instance,
// a warm-up sequence on a WARMUP=64 instance, and a random soak of both against a reference model.
module tb_masked_rng_source;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seed_start;
    logic [7:0] seed_data;
    logic       seed_valid;
    logic       rnd_ready;

    logic       sr0, rv0, err0, busy0;
    logic [1:0] rnd0;
    logic       sr64, rv64, err64, busy64;
    logic [1:0] rnd64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    masked_rng_source #(.WARMUP(0)) dut0 (
        .clk(clk), .rst(rst), .seed_start(seed_start), .seed_data(seed_data),
        .seed_valid(seed_valid), .seed_ready(sr0), .rnd(rnd0), .rnd_valid(rv0),
        .rnd_ready(rnd_ready), .err(err0), .busy(busy0)
    );

    masked_rng_source #(.WARMUP(64)) dut64 (
        .clk(clk), .rst(rst), .seed_start(seed_start), .seed_data(seed_data),
        .seed_valid(seed_valid), .seed_ready(sr64), .rnd(rnd64), .rnd_valid(rv64),
        .rnd_ready(rnd_ready), .err(err64), .busy(busy64)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic r);
        seed_start = s;
        seed_valid = v;
        seed_data  = d;
        rnd_ready  = r;
    endtask

    function automatic logic [31:0] gal(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = (y >> 1) ^ (y[0] ? 32'h80200003 : 32'h0);
        return y;
    endfunction

    // Directed vectors: inputs for one cycle plus the outputs expected in that cycle (before its edge).
    typedef struct {
        logic       st, sv;
        logic [7:0] sd;
        logic       rr;
        logic       sr, rv;
        logic [1:0] rnd;
        logic       er, bz;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic sv, input logic [7:0] sd, input logic rr,
                                input logic sr, input logic rv, input logic [1:0] rn,
                                input logic er, input logic bz);
        vec_t t;
        t.st = st; t.sv = sv; t.sd = sd; t.rr = rr;
        t.sr = sr; t.rv = rv; t.rnd = rn; t.er = er; t.bz = bz;
        return t;
    endfunction

    // Reference model: states 0 IDLE, 1 LOAD, 2 WARM, 3 RUN, 4 ERROR.
    typedef struct {
        logic [2:0]  st;
        logic [31:0] lfsr;
        int          beat;
        int          warm;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = 3'd0; m.lfsr = 32'h0; m.beat = 0; m.warm = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic s, input logic v, input logic [7:0] d,
                                   input logic r, input int warmup);
        mdl_t n;
        n = m;
        if (s) begin
            n.st = 3'd1;
            n.beat = 0;
        end else if (m.st == 3'd1) begin
            if (v) begin
                n.lfsr = {m.lfsr[23:0], d};
                if (m.beat == 3) begin
                    if (n.lfsr == 32'h0) n.st = 3'd4;
                    else if (warmup == 0) n.st = 3'd3;
                    else begin
                        n.st = 3'd2;
                        n.warm = warmup;
                    end
                end else begin
                    n.beat = m.beat + 1;
                end
            end
        end else if (m.st == 3'd2) begin
            n.lfsr = gal(m.lfsr, 2);
            n.warm = m.warm - 1;
            if (m.warm == 1) n.st = 3'd3;
        end else if (m.st == 3'd3) begin
            if (m.lfsr == 32'h0) n.st = 3'd4;
            else if (r) n.lfsr = gal(m.lfsr, 2);
        end
        return n;
    endfunction

    // Packed as {seed_ready, rnd_valid, err, busy, rnd}.
    function automatic logic [5:0] mout(input mdl_t m);
        return {m.st == 3'd1, (m.st == 3'd3) && (m.lfsr != 32'h0), m.st == 3'd4,
                (m.st == 3'd1) || (m.st == 3'd2), m.lfsr[1:0]};
    endfunction

    localparam int NV = 38;
    vec_t tbl [NV];
    mdl_t m0, m64;
    logic zero_seed;
    logic [31:0] exp_lfsr;

    initial begin
        // seed path 0x12345678 with a gap, two advances, then a hold
        tbl[0]  = mk(1, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0);
        tbl[1]  = mk(0, 1, 8'h12, 0, 1, 0, 2'd0, 0, 1);
        tbl[2]  = mk(0, 1, 8'h34, 0, 1, 0, 2'd2, 0, 1);
        tbl[3]  = mk(0, 0, 8'h00, 0, 1, 0, 2'd0, 0, 1);
        tbl[4]  = mk(0, 1, 8'h56, 0, 1, 0, 2'd0, 0, 1);
        tbl[5]  = mk(0, 1, 8'h78, 0, 1, 0, 2'd2, 0, 1);
        tbl[6]  = mk(0, 0, 8'h00, 0, 0, 1, 2'd0, 0, 0);
        tbl[7]  = mk(0, 0, 8'h00, 1, 0, 1, 2'd0, 0, 0);
        tbl[8]  = mk(0, 0, 8'h00, 0, 0, 1, 2'd2, 0, 0);
        tbl[9]  = mk(0, 0, 8'h00, 1, 0, 1, 2'd2, 0, 0);
        for (int i = 10; i < 15; i++) tbl[i] = mk(0, 0, 8'h00, 0, 0, 1, 2'd0, 0, 0);
        // reseed coincident with rnd_ready, then restart after two beats
        tbl[15] = mk(1, 0, 8'h00, 1, 0, 1, 2'd0, 0, 0);
        tbl[16] = mk(0, 1, 8'hAA, 0, 1, 0, 2'd0, 0, 1);
        tbl[17] = mk(0, 1, 8'hBB, 0, 1, 0, 2'd2, 0, 1);
        tbl[18] = mk(1, 1, 8'hCC, 0, 1, 0, 2'd3, 0, 1);
        tbl[19] = mk(0, 1, 8'h01, 0, 1, 0, 2'd3, 0, 1);
        tbl[20] = mk(0, 1, 8'h02, 0, 1, 0, 2'd1, 0, 1);
        tbl[21] = mk(0, 1, 8'h03, 0, 1, 0, 2'd2, 0, 1);
        tbl[22] = mk(0, 1, 8'h04, 0, 1, 0, 2'd3, 0, 1);
        tbl[23] = mk(0, 0, 8'h00, 0, 0, 1, 2'd0, 0, 0);
        // all-zero seed lands in ERROR, then recovery with seed 0x00000001
        tbl[24] = mk(1, 0, 8'h00, 0, 0, 1, 2'd0, 0, 0);
        for (int i = 25; i < 29; i++) tbl[i] = mk(0, 1, 8'h00, 0, 1, 0, 2'd0, 0, 1);
        tbl[29] = mk(0, 0, 8'h00, 1, 0, 0, 2'd0, 1, 0);
        tbl[30] = mk(0, 1, 8'h55, 0, 0, 0, 2'd0, 1, 0);
        tbl[31] = mk(1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0);
        for (int i = 32; i < 35; i++) tbl[i] = mk(0, 1, 8'h00, 0, 1, 0, 2'd0, 0, 1);
        tbl[35] = mk(0, 1, 8'h01, 0, 1, 0, 2'd0, 0, 1);
        tbl[36] = mk(0, 0, 8'h00, 0, 0, 1, 2'd1, 0, 0);
        tbl[37] = mk(0, 0, 8'h00, 0, 0, 1, 2'd1, 0, 0);

        drive(0, 0, 8'h00, 0);
        #3;
        chk("reset_outputs", {26'h0, sr0, rv0, err0, busy0, rnd0}, 32'h0);
        chk("reset_outputs_w", {26'h0, sr64, rv64, err64, busy64, rnd64}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_quiet", {26'h0, sr0, rv0, err0, busy0, rnd0}, 32'h0);
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].st, tbl[i].sv, tbl[i].sd, tbl[i].rr);
            #1;
            chk($sformatf("vec%0d_seed_ready", i), {31'h0, sr0}, {31'h0, tbl[i].sr});
            chk($sformatf("vec%0d_rnd_valid", i), {31'h0, rv0}, {31'h0, tbl[i].rv});
            chk($sformatf("vec%0d_rnd", i), {30'h0, rnd0}, {30'h0, tbl[i].rnd});
            chk($sformatf("vec%0d_err", i), {31'h0, err0}, {31'h0, tbl[i].er});
            chk($sformatf("vec%0d_busy", i), {31'h0, busy0}, {31'h0, tbl[i].bz});
        end

        // asynchronous reset between edges while RUN shows a non-zero value
        @(negedge clk);
        drive(0, 0, 8'h00, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("midcycle_rst", {26'h0, sr0, rv0, err0, busy0, rnd0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // warm-up: busy for exactly 64 cycles after the last beat, then 128 steps on
        @(negedge clk); drive(1, 0, 8'h00, 0);
        @(negedge clk); drive(0, 1, 8'h12, 0);
        @(negedge clk); drive(0, 1, 8'h34, 0);
        @(negedge clk); drive(0, 1, 8'h56, 0);
        @(negedge clk); drive(0, 1, 8'h78, 0);
        @(negedge clk); drive(0, 0, 8'h00, 0);
        for (int k = 0; k < 64; k++) begin
            #1;
            chk($sformatf("warm%0d_busy_valid", k), {30'h0, busy64, rv64}, 32'h2);
            @(negedge clk);
        end
        #1;
        exp_lfsr = gal(32'h12345678, 128);
        chk("warm_done_valid", {30'h0, busy64, rv64}, 32'h1);
        chk("warm_done_lfsr", dut64.lfsr, exp_lfsr);
        chk("warm_done_rnd", {30'h0, rnd64}, {30'h0, exp_lfsr[1:0]});
        rnd_ready = 1'b1;
        @(negedge clk);
        rnd_ready = 1'b0;
        #1;
        exp_lfsr = gal(32'h12345678, 130);
        chk("warm_next_lfsr", dut64.lfsr, exp_lfsr);
        chk("warm_next_rnd", {30'h0, rnd64}, {30'h0, exp_lfsr[1:0]});

        // random soak of both instances against the reference model
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b0;
        m0 = mreset();
        m64 = mreset();
        zero_seed = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            #1;
            chk("soak_w0", {26'h0, sr0, rv0, err0, busy0, rnd0}, {26'h0, mout(m0)});
            chk("soak_w64", {26'h0, sr64, rv64, err64, busy64, rnd64}, {26'h0, mout(m64)});
            chk("soak_valid_nonzero", {31'h0, rv0 && (dut0.lfsr == 32'h0)}, 32'h0);
            if (i == 2 || $urandom_range(299) == 0) begin
                seed_start = 1'b1;
                zero_seed = ($urandom_range(3) == 0);
            end else begin
                seed_start = 1'b0;
            end
            seed_valid = 1'($urandom_range(1));
            seed_data  = zero_seed ? 8'h00 : 8'($urandom_range(255));
            rnd_ready  = ($urandom_range(3) != 0);
            m0  = mstep(m0, seed_start, seed_valid, seed_data, rnd_ready, 0);
            m64 = mstep(m64, seed_start, seed_valid, seed_data, rnd_ready, 64);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
